// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the FIR datapath responder.
// FIR_SATURATE_EN (see fir_mac) selects clamped instead of wrapped results.
package fir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READY,
        MAC,
        OUT
    } state_t;

    localparam int DEFAULT_MAX_TAPS  = 16;
    localparam int DEFAULT_DATA_W    = 16;
    localparam int DEFAULT_FRAC_BITS = 15;

    // Headroom of log2(taps) bits lets every tap add a full-scale product.
    function automatic int acc_width(input int data_w, input int max_taps);
        return 2 * data_w + $clog2(max_taps);
    endfunction

    function automatic int effective_taps(input logic [31:0] tap_count, input int max_taps);
        if (tap_count == 32'd0) begin
            return 1;
        end
        if (tap_count > 32'(max_taps)) begin
            return max_taps;
        end
        return int'(tap_count);
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Serial signed multiply-accumulate and result formatting stage.
// With FIR_SATURATE_EN defined the result is clamped to DATA_W; otherwise it wraps.
module fir_mac #(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 15,
    parameter int ACC_W     = 36
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clear,
    input  logic                     enable,
    input  logic                     load_out,
    input  logic signed [DATA_W-1:0] coeff,
    input  logic signed [DATA_W-1:0] sample,
    output logic [31:0]              output_data,
    output logic                     output_data_valid
);

    logic signed [2*DATA_W-1:0] product;
    logic signed [ACC_W-1:0]    product_ext;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    shifted;
    logic [31:0]                result;

    assign product     = coeff * sample;
    assign product_ext = {{(ACC_W - 2 * DATA_W){product[2*DATA_W-1]}}, product};
    assign shifted     = acc >>> FRAC_BITS;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + product_ext;
        end
    end

`ifdef FIR_SATURATE_EN
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

    logic [DATA_W-1:0] clamped;

    // In range exactly when every bit from the DATA_W sign bit upward agrees.
    always_comb begin
        clamped = shifted[DATA_W-1:0];
        if (!((&shifted[ACC_W-1:DATA_W-1]) || !(|shifted[ACC_W-1:DATA_W-1]))) begin
            clamped = shifted[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

    assign result = {{(32 - DATA_W){clamped[DATA_W-1]}}, clamped};
`else
    assign result = 32'(shifted);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            output_data       <= '0;
            output_data_valid <= 1'b0;
        end else begin
            output_data_valid <= load_out;
            if (load_out) begin
                output_data <= result;
            end
        end
    end

endmodule

// File: rtl/fir_datapath.sv
// FIR datapath responder: coefficient load, delay line and serial MAC sequencing.
// Build option FIR_SATURATE_EN (handled in fir_mac) clamps results to the sample range.
module fir_datapath
    import fir_pkg::*;
#(
    parameter int MAX_TAPS  = DEFAULT_MAX_TAPS,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int FRAC_BITS = DEFAULT_FRAC_BITS
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] tap_count,
    input  logic [31:0] coeff_data,
    input  logic        coeff_data_valid,
    input  logic [31:0] x_data,
    input  logic        x_data_valid,
    input  logic        compute,
    output logic        coefficient_loading_complete,
    output logic        output_data_valid,
    output logic [31:0] output_data,
    output logic        protocol_error
);

    localparam int IDX_W = $clog2(MAX_TAPS);
    localparam int ACC_W = acc_width(DATA_W, MAX_TAPS);

    state_t state;
    state_t next_state;

    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         last_idx;
    logic [IDX_W-1:0]         new_last;
    logic signed [DATA_W-1:0] coeff [MAX_TAPS];
    logic signed [DATA_W-1:0] x_hist [MAX_TAPS];
    logic                     compute_q;
    logic                     flush;

    logic load_first;
    logic load_next;
    logic accept_x;
    logic drop;
    logic mac_en;
    logic out_load;

    logic unused_upper;
    assign unused_upper = ^{x_data[31:DATA_W], coeff_data[31:DATA_W]};

    assign new_last = IDX_W'(effective_taps(tap_count, MAX_TAPS) - 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A reload from READY behaves exactly like the first load from IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (coeff_data_valid) begin
                    next_state = (new_last == '0) ? READY : LOAD;
                end
            end
            LOAD: begin
                if (coeff_data_valid && (idx == last_idx)) begin
                    next_state = READY;
                end
            end
            READY: begin
                if (coeff_data_valid) begin
                    next_state = (new_last == '0) ? READY : LOAD;
                end else if (x_data_valid) begin
                    next_state = MAC;
                end
            end
            MAC: begin
                if (idx == last_idx) begin
                    next_state = OUT;
                end
            end
            OUT:     next_state = READY;
            default: next_state = IDLE;
        endcase
    end

    // Coefficient strobes take priority over samples in READY; the loser is a dropped strobe.
    always_comb begin
        load_first = 1'b0;
        load_next  = 1'b0;
        accept_x   = 1'b0;
        drop       = 1'b0;
        mac_en     = 1'b0;
        out_load   = 1'b0;
        case (state)
            IDLE: load_first = coeff_data_valid;
            LOAD: load_next  = coeff_data_valid;
            READY: begin
                load_first = coeff_data_valid;
                accept_x   = x_data_valid && !coeff_data_valid;
                drop       = x_data_valid && coeff_data_valid;
            end
            MAC: begin
                mac_en = 1'b1;
                drop   = x_data_valid || coeff_data_valid;
            end
            OUT: begin
                out_load = 1'b1;
                drop     = x_data_valid || coeff_data_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx                          <= '0;
            last_idx                     <= '0;
            coefficient_loading_complete <= 1'b0;
            protocol_error               <= 1'b0;
            compute_q                    <= 1'b0;
            for (int k = 0; k < MAX_TAPS; k++) begin
                coeff[k] <= '0;
            end
        end else begin
            compute_q      <= compute;
            protocol_error <= protocol_error | drop;
            if (load_first) begin
                last_idx                     <= new_last;
                coeff[0]                     <= coeff_data[DATA_W-1:0];
                idx                          <= IDX_W'(1);
                coefficient_loading_complete <= (new_last == '0);
            end else if (load_next) begin
                coeff[idx] <= coeff_data[DATA_W-1:0];
                idx        <= idx + 1'b1;
                if (idx == last_idx) begin
                    coefficient_loading_complete <= 1'b1;
                end
            end else if (accept_x) begin
                idx <= '0;
            end else if (mac_en) begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign flush = (compute && !compute_q) || load_first;

    // A flush coinciding with an accepted sample clears first, so only the new sample survives.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < MAX_TAPS; k++) begin
                x_hist[k] <= '0;
            end
        end else if (accept_x) begin
            x_hist[0] <= x_data[DATA_W-1:0];
            for (int k = 1; k < MAX_TAPS; k++) begin
                x_hist[k] <= flush ? '0 : x_hist[k-1];
            end
        end else if (flush) begin
            for (int k = 0; k < MAX_TAPS; k++) begin
                x_hist[k] <= '0;
            end
        end
    end

    fir_mac #(
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clk               (clk),
        .rstn              (rstn),
        .clear             (accept_x),
        .enable            (mac_en),
        .load_out          (out_load),
        .coeff             (coeff[idx]),
        .sample            (x_hist[idx]),
        .output_data       (output_data),
        .output_data_valid (output_data_valid)
    );

endmodule

// File: tb/tb_fir_datapath.sv
// Scoreboard bench for fir_datapath against an arithmetic FIR reference model.
// Expected saturation results follow FIR_SATURATE_EN when it is defined.
module tb_fir_datapath;

    localparam int MAX_TAPS = 16;

`ifdef FIR_SATURATE_EN
    localparam logic [31:0] SAT_Y = 32'h0000_7FFF;
`else
    localparam logic [31:0] SAT_Y = 32'h0000_FFFC;
`endif

    typedef struct {
        logic [31:0] y;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] tap_count = '0;
    logic [31:0] coeff_data = '0;
    logic        coeff_data_valid = 1'b0;
    logic [31:0] x_data = '0;
    logic        x_data_valid = 1'b0;
    logic        compute = 1'b0;
    logic        coefficient_loading_complete;
    logic        output_data_valid;
    logic [31:0] output_data;
    logic        protocol_error;

    int   compared = 0;
    int   mismatched = 0;
    int   cycle = 0;
    int   valid_seen = 0;
    exp_t sb[$];
    exp_t mon_e;

    int          m_coeff [MAX_TAPS];
    int          m_hist [MAX_TAPS];
    int          n_model = 1;
    logic        perr_exp = 1'b0;
    logic [31:0] stage [MAX_TAPS];

    fir_datapath dut (
        .clk                          (clk),
        .rstn                         (rstn),
        .tap_count                    (tap_count),
        .coeff_data                   (coeff_data),
        .coeff_data_valid             (coeff_data_valid),
        .x_data                       (x_data),
        .x_data_valid                 (x_data_valid),
        .compute                      (compute),
        .coefficient_loading_complete (coefficient_loading_complete),
        .output_data_valid            (output_data_valid),
        .output_data                  (output_data),
        .protocol_error               (protocol_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every result pulse is matched against the oldest pending expectation.
    always @(negedge clk) begin
        if (rstn && output_data_valid) begin
            valid_seen++;
            if (sb.size() == 0) begin
                check_output("unexpected_valid", {31'b0, output_data_valid}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_output("result", output_data, mon_e.y);
                check_output("latency", 32'(cycle), 32'(mon_e.due));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sext16(input logic [31:0] v);
        logic [15:0] lo;
        lo = v[15:0];
        return int'($signed(lo));
    endfunction

    function automatic logic [31:0] model_y();
        longint acc;
        acc = 0;
        for (int k = 0; k < n_model; k++) begin
            acc += longint'(m_coeff[k]) * longint'(m_hist[k]);
        end
        acc = acc >>> 15;
`ifdef FIR_SATURATE_EN
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
`endif
        return acc[31:0];
    endfunction

    task automatic clear_hist();
        for (int k = 0; k < MAX_TAPS; k++) m_hist[k] = 0;
    endtask

    task automatic load_coeffs(input logic [31:0] tc);
        n_model = (tc == 0) ? 1 : ((tc > MAX_TAPS) ? MAX_TAPS : int'(tc));
        clear_hist();
        tap_count = tc;
        for (int k = 0; k < n_model; k++) begin
            coeff_data       = stage[k];
            coeff_data_valid = 1'b1;
            tick();
            coeff_data_valid = 1'b0;
            tap_count        = $urandom_range(0, 100);
            m_coeff[k]       = sext16(stage[k]);
            check_output($sformatf("complete_n%0d_k%0d", n_model, k),
                         {31'b0, coefficient_loading_complete}, {31'b0, (k == n_model - 1)});
        end
    endtask

    // inject: 0 none, 1 sample strobe during MAC, 2 coefficient strobe during MAC.
    task automatic apply_stimulus(input logic [31:0] x, input bit use_const, input logic [31:0] yc,
                                  input int inject, input bit with_flush);
        exp_t e;
        x_data       = x;
        x_data_valid = 1'b1;
        compute      = with_flush;
        tick();
        x_data_valid = 1'b0;
        compute      = 1'b0;
        if (with_flush) clear_hist();
        for (int k = MAX_TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = sext16(x);
        e.y   = use_const ? yc : model_y();
        e.due = cycle + n_model + 1;
        sb.push_back(e);
        for (int w = 0; w < n_model + 1; w++) begin
            if (w == 0 && inject == 1) begin
                x_data       = $urandom;
                x_data_valid = 1'b1;
                perr_exp     = 1'b1;
            end
            if (w == 0 && inject == 2) begin
                coeff_data       = $urandom;
                coeff_data_valid = 1'b1;
                perr_exp         = 1'b1;
            end
            tick();
            x_data_valid     = 1'b0;
            coeff_data_valid = 1'b0;
        end
        check_output("protocol_error", {31'b0, protocol_error}, {31'b0, perr_exp});
    endtask

    task automatic pulse_compute();
        compute = 1'b1;
        tick();
        compute = 1'b0;
        clear_hist();
    endtask

    function automatic logic [31:0] pick_value();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_7FFF;
            1:       return 32'hFFFF_8000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int v0;
        clear_hist();
        repeat (2) tick();
        check_output("reset_data", output_data, 32'd0);
        check_output("reset_valid", {31'b0, output_data_valid}, 32'd0);
        check_output("reset_complete", {31'b0, coefficient_loading_complete}, 32'd0);
        check_output("reset_perr", {31'b0, protocol_error}, 32'd0);
        rstn = 1'b1;
        tick();

        stage[0] = 32'h4000; stage[1] = 32'h2000; stage[2] = 32'h0; stage[3] = 32'h0;
        load_coeffs(32'd4);
        apply_stimulus(32'h1000, 1'b1, 32'h0000_0800, 0, 1'b0);
        apply_stimulus(32'h2000, 1'b1, 32'h0000_1400, 0, 1'b0);
        pulse_compute();
        apply_stimulus(32'h1000, 1'b1, 32'h0000_0800, 0, 1'b0);

        apply_stimulus(32'h3000, 1'b1, 32'h0000_1C00, 1, 1'b0);
        apply_stimulus(32'h1000, 1'b1, 32'h0000_1400, 0, 1'b0);

        stage[0] = 32'h1234;
        load_coeffs(32'd0);
        apply_stimulus(32'h2000, 1'b0, 32'd0, 0, 1'b0);

        for (int k = 0; k < MAX_TAPS; k++) stage[k] = pick_value();
        load_coeffs(32'd40);
        apply_stimulus(pick_value(), 1'b0, 32'd0, 0, 1'b0);

        stage[0] = 32'h7FFF; stage[1] = 32'h7FFF;
        load_coeffs(32'd2);
        apply_stimulus(32'h7FFF, 1'b1, 32'h0000_7FFE, 0, 1'b0);
        apply_stimulus(32'h7FFF, 1'b1, SAT_Y, 0, 1'b0);

        for (int set = 0; set < 6; set++) begin
            for (int k = 0; k < MAX_TAPS; k++) stage[k] = pick_value();
            load_coeffs($urandom_range(0, 20));
            for (int s = 0; s < 8; s++) begin
                if ($urandom_range(0, 5) == 0) pulse_compute();
                apply_stimulus(pick_value(), 1'b0, 32'd0,
                               ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0,
                               $urandom_range(0, 4) == 0);
            end
        end

        stage[0] = 32'h4000; stage[1] = 32'h2000; stage[2] = 32'h1000; stage[3] = 32'h0800;
        load_coeffs(32'd4);
        apply_stimulus(32'h4000, 1'b0, 32'd0, 0, 1'b0);
        x_data       = 32'h1000;
        x_data_valid = 1'b1;
        tick();
        x_data_valid = 1'b0;
        repeat (2) tick();
        rstn = 1'b0;
        #1;
        check_output("midpass_reset_data", output_data, 32'd0);
        check_output("midpass_reset_valid", {31'b0, output_data_valid}, 32'd0);
        check_output("midpass_reset_complete", {31'b0, coefficient_loading_complete}, 32'd0);
        check_output("midpass_reset_perr", {31'b0, protocol_error}, 32'd0);
        v0 = valid_seen;
        repeat (3) tick();
        rstn     = 1'b1;
        perr_exp = 1'b0;
        clear_hist();
        tick();
        x_data       = 32'h2000;
        x_data_valid = 1'b1;
        tick();
        x_data_valid = 1'b0;
        repeat (20) tick();
        check_output("idle_no_result", 32'(valid_seen), 32'(v0));
        check_output("idle_complete", {31'b0, coefficient_loading_complete}, 32'd0);
        check_output("idle_perr", {31'b0, protocol_error}, 32'd0);

        repeat (5) tick();
        check_output("pending_results", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
